// File: rtl/sseg_scan_reader.sv
// Passive monitor for a multiplexed common-anode 7-segment bus: decodes each digit once its pins settle.
// Optional decimal-point capture is enabled with `define SSEG_SCAN_READER_DP_EN.
module sseg_scan_reader #(
    parameter int N_DIGITS      = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [N_DIGITS-1:0]   i_an,
    input  logic [6:0]            i_sseg_ca,
`ifdef SSEG_SCAN_READER_DP_EN
    input  logic                  i_dp,
    output logic [N_DIGITS-1:0]   o_dp_out,
`endif
    output logic [4*N_DIGITS-1:0] o_digits,
    output logic [N_DIGITS-1:0]   o_digit_valid,
    output logic                  o_frame_done,
    output logic                  o_err,
    output logic [1:0]            o_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, COUNT = 2'd1, HOLD = 2'd2} state_t;

`ifdef SSEG_SCAN_READER_DP_EN
    localparam int PW = N_DIGITS + 8;
`else
    localparam int PW = N_DIGITS + 7;
`endif
    localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
    localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

    state_t                  r_state;
    logic [PW-1:0]           r_in_q;
    logic [CW-1:0]           r_cnt;
    logic [N_DIGITS-1:0]     r_seen;
    logic [4*N_DIGITS-1:0]   r_digits;
    logic [N_DIGITS-1:0]     r_valid;
    logic                    r_frame_done;
    logic                    r_err;

    logic [PW-1:0]           w_pins;
    logic [N_DIGITS-1:0]     w_an_q;
    logic [6:0]              w_ca_q;
    logic [N_DIGITS-1:0]     w_pin_low;
    logic                    w_pins_onehot;
    logic [IW-1:0]           w_idx;
    logic                    w_hit;
    logic                    w_blank;
    logic [3:0]              w_val;
    logic                    w_same;
    logic                    w_fire;
    logic [N_DIGITS-1:0]     w_seen_set;
    logic                    w_all;

`ifdef SSEG_SCAN_READER_DP_EN
    logic [N_DIGITS-1:0]     r_dp_out;
    assign w_pins   = {i_an, i_sseg_ca, i_dp};
    assign o_dp_out = r_dp_out;
`else
    assign w_pins   = {i_an, i_sseg_ca};
`endif

    assign w_an_q        = r_in_q[PW-1 -: N_DIGITS];
    assign w_ca_q        = r_in_q[PW-N_DIGITS-1 -: 7];
    assign w_pin_low     = ~i_an;
    assign w_pins_onehot = (w_pin_low != '0) &&
                           ((w_pin_low & (w_pin_low - N_DIGITS'(1))) == '0);
    assign w_same        = (w_pins == r_in_q);
    assign w_fire        = (r_state == COUNT) && w_same && (r_cnt == CNT_MAX);
    assign w_seen_set    = r_seen | (N_DIGITS'(1) << w_idx);
    assign w_all         = &w_seen_set;

    // Only meaningful in COUNT, where in_q.AN is guaranteed one-hot-low.
    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (!w_an_q[i]) w_idx = IW'(i);
        end
    end

    always_comb begin
        w_hit   = 1'b1;
        w_blank = 1'b0;
        w_val   = 4'h0;
        case (w_ca_q)
            7'b0000001: w_val = 4'h0;
            7'b1001111: w_val = 4'h1;
            7'b0010010: w_val = 4'h2;
            7'b0000110: w_val = 4'h3;
            7'b1001100: w_val = 4'h4;
            7'b0100100: w_val = 4'h5;
            7'b0100000: w_val = 4'h6;
            7'b0001111: w_val = 4'h7;
            7'b0000000: w_val = 4'h8;
            7'b0000100: w_val = 4'h9;
            7'b0001000: w_val = 4'hA;
            7'b1100000: w_val = 4'hB;
            7'b0110001: w_val = 4'hC;
            7'b1000010: w_val = 4'hD;
            7'b0110000: w_val = 4'hE;
            7'b0111000: w_val = 4'hF;
            7'b1111111: begin w_hit = 1'b0; w_blank = 1'b1; end
            default:    w_hit = 1'b0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            r_state      <= IDLE;
            r_in_q       <= '1;
            r_cnt        <= '0;
            r_seen       <= '0;
            r_digits     <= '0;
            r_valid      <= '0;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
`ifdef SSEG_SCAN_READER_DP_EN
            r_dp_out     <= '0;
`endif
        end else begin
            r_in_q       <= w_pins;
            r_frame_done <= 1'b0;
            r_err        <= 1'b0;
            if (!w_same) begin
                r_cnt   <= '0;
                r_state <= w_pins_onehot ? COUNT : IDLE;
            end else begin
                if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
                if (w_fire) begin
                    r_state        <= HOLD;
                    r_valid[w_idx] <= w_hit;
                    if (w_hit) r_digits[4*w_idx +: 4] <= w_val;
                    r_err          <= !w_hit && !w_blank;
                    r_frame_done   <= w_all;
                    r_seen         <= w_all ? '0 : w_seen_set;
`ifdef SSEG_SCAN_READER_DP_EN
                    r_dp_out[w_idx] <= ~r_in_q[0];
`endif
                end
            end
        end
    end

    assign o_digits      = r_digits;
    assign o_digit_valid = r_valid;
    assign o_frame_done  = r_frame_done;
    assign o_err         = r_err;
    assign o_state       = r_state;

endmodule

// File: tb/tb_sseg_scan_reader.sv
// Bench for sseg_scan_reader: directed scenarios plus random bus traffic against a run-length model.
module tb_sseg_scan_reader;
  localparam int N  = 4;
  localparam int SC = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   an = '1;
  logic [6:0]     ca = '1;
  logic           dp = 1'b1;
  logic [4*N-1:0] o_digits;
  logic [N-1:0]   o_valid;
  logic           o_fd;
  logic           o_err;
  logic [1:0]     o_state;
`ifdef SSEG_SCAN_READER_DP_EN
  logic [N-1:0]   o_dp_out;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int fd_cnt   = 0;
  int err_cnt  = 0;
  bit cmp_en   = 1'b0;

  logic [4*N-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  sseg_scan_reader #(.N_DIGITS(N), .STABLE_CYCLES(SC)) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_an(an), .i_sseg_ca(ca),
`ifdef SSEG_SCAN_READER_DP_EN
    .i_dp(dp), .o_dp_out(o_dp_out),
`endif
    .o_digits(o_digits), .o_digit_valid(o_valid), .o_frame_done(o_fd),
    .o_err(o_err), .o_state(o_state)
  );

  logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

  // ---------------- behavioural model ----------------
  // A value is captured when it has been present at exactly SC+1 consecutive edges.
  logic [N+7:0]   m_prev;
  int             m_run;
  logic [3:0]     m_dig [N];
  logic [N-1:0]   m_valid;
  logic [N-1:0]   m_seen;
  logic [N-1:0]   m_dp;
  logic           m_fd;
  logic           m_err;

  function automatic logic [4*N-1:0] m_digits_flat();
    logic [4*N-1:0] v;
    for (int i = 0; i < N; i++) v[4*i +: 4] = m_dig[i];
    return v;
  endfunction

  always @(posedge clk) begin
    m_fd  = 1'b0;
    m_err = 1'b0;
    if (!rst_n) begin
      for (int i = 0; i < N; i++) m_dig[i] = 4'h0;
      m_valid = '0; m_seen = '0; m_dp = '0;
      m_prev  = '1; m_run = 1;
    end else begin
      if ({an, ca, dp} == m_prev) begin
        if (m_run <= SC + 1) m_run++;
      end else begin
        m_prev = {an, ca, dp};
        m_run  = 1;
      end
      if (m_run == SC + 1 && $countones(~an) == 1) begin
        int k;
        int v;
        k = 0;
        for (int i = 0; i < N; i++) if (!an[i]) k = i;
        v = -1;
        for (int j = 0; j < 16; j++) if (seg_tab[j] == ca) v = j;
        if (v >= 0) begin
          m_dig[k]   = 4'(v);
          m_valid[k] = 1'b1;
        end else begin
          m_valid[k] = 1'b0;
          m_err      = (ca != 7'b1111111);
        end
        m_dp[k]   = ~dp;
        m_seen[k] = 1'b1;
        if (m_seen == '1) begin
          m_fd   = 1'b1;
          m_seen = '0;
          exp_q.push_back(m_digits_flat());
        end
      end
    end
  end

  // ---------------- checks ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("digits", 32'(o_digits), 32'(m_digits_flat()));
      check("valid", 32'(o_valid), 32'(m_valid));
      check("frame_done", 32'(o_fd), 32'(m_fd));
      check("err", 32'(o_err), 32'(m_err));
`ifdef SSEG_SCAN_READER_DP_EN
      check("dp_out", 32'(o_dp_out), 32'(m_dp));
`endif
      if (o_fd === 1'b1) begin
        fd_cnt++;
        if (exp_q.size() == 0) check("frame_q_empty", 32'(o_digits), 32'hFFFF_FFFF);
        else check("frame_digits", 32'(o_digits), 32'(exp_q.pop_front()));
      end
      if (o_err === 1'b1) err_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [N-1:0] a, input logic [6:0] c, input int n);
    an = a; ca = c;
    tick(n);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
  endtask

  task automatic scan4(input logic [6:0] c0, input logic [6:0] c1,
                       input logic [6:0] c2, input logic [6:0] c3);
    hold(4'b1110, c0, 6);
    hold(4'b1101, c1, 6);
    hold(4'b1011, c2, 6);
    hold(4'b0111, c3, 6);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fd0;
    int err0;
    int r;
    tick(1);
    do_reset();
    cmp_en = 1'b1;
    check("reset_digits", 32'(o_digits), 32'h0);
    check("reset_valid", 32'(o_valid), 32'h0);
    check("reset_state", 32'(o_state), 32'h0);
    tick(20);
    check("idle_fd_cnt", 32'(fd_cnt), 32'h0);
    check("idle_err_cnt", 32'(err_cnt), 32'h0);

    an = 4'b1110; ca = 7'b0010010;
    tick(4);
    check("lat_k3_valid", 32'(o_valid), 32'h0);
    tick(1);
    check("lat_k4_digit", 32'(o_digits[3:0]), 32'h2);
    check("lat_k4_valid", 32'(o_valid), 32'h1);

    fd0 = fd_cnt;
    hold(4'b1110, 7'b1001111, 6);
    hold(4'b1101, 7'b0001000, 6);
    hold(4'b1011, 7'b1000010, 6);
    check("scan_fd_before_d3", 32'(fd_cnt - fd0), 32'h0);
    hold(4'b0111, 7'b0000000, 6);
    check("scan_digits", 32'(o_digits), 32'h8DA1);
    check("scan_valid", 32'(o_valid), 32'hF);
    check("scan_fd_once", 32'(fd_cnt - fd0), 32'h1);

    err0 = err_cnt;
    hold(4'b1101, 7'b1010101, 8);
    check("bad_err_once", 32'(err_cnt - err0), 32'h1);
    check("bad_valid1", 32'(o_valid[1]), 32'h0);
    check("bad_digit1", 32'(o_digits[7:4]), 32'hA);

    hold(4'b1110, 7'b0000001, 6);
    hold(4'b1110, 7'b0000110, 2);
    tick(1);
    check("glitch_ignored", 32'(o_digits[3:0]), 32'h0);
    hold(4'b1110, 7'b0000001, 6);
    check("glitch_recap", 32'(o_digits[3:0]), 32'h0);
    hold(4'b1100, 7'b0000001, 10);
    check("overlap_digits", 32'(o_digits), 32'h8DA0);
    check("overlap_valid", 32'(o_valid), 32'hD);

    do_reset();
    hold(4'b1110, seg_tab[5], 6);
    hold(4'b1101, seg_tab[6], 6);
    do_reset();
    check("midrst_digits", 32'(o_digits), 32'h0);
    check("midrst_valid", 32'(o_valid), 32'h0);
    fd0 = fd_cnt;
    scan4(seg_tab[3], seg_tab[12], seg_tab[9], seg_tab[15]);
    tick(2);
    check("midrst_fd_once", 32'(fd_cnt - fd0), 32'h1);
    check("midrst_digits_full", 32'(o_digits), 32'hF9C3);

    for (int it = 0; it < 400; it++) begin
      logic [N-1:0] a;
      logic [6:0]   c;
      r = $urandom_range(0, 9);
      if (r < 7) a = ~(N'(1) << $urandom_range(0, N-1));
      else       a = N'($urandom_range(0, (1 << N) - 1));
      r = $urandom_range(0, 13);
      if (r < 10)      c = seg_tab[$urandom_range(0, 15)];
      else if (r == 10) c = 7'b1111111;
      else             c = 7'($urandom_range(0, 127));
      dp = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 59) == 0) do_reset();
      hold(a, c, $urandom_range(1, 8));
    end
    hold('1, 7'b1111111, 8);
    check("frame_q_drained", 32'(exp_q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
